// File: rtl/rr_request_arbiter.sv
// rr_request_arbiter: 16-way fixed/round-robin arbiter holding each grant until done, request drop or timeout.
module rr_request_arbiter #(
   parameter int N       = 16,
   parameter int IDW     = 4,
   parameter int TIMEOUT = 255
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic [N-1:0]   req,
   input  logic           mode,
   input  logic           done,
   output logic           gnt_valid,
   output logic [IDW-1:0] gnt_id,
   output logic [N-1:0]   gnt_onehot,
   output logic           timeout_pulse
);
   typedef enum logic {IDLE, GRANT} state_t;
   state_t state, state_nxt;
   logic [IDW-1:0] last_id, ptr, win;
   logic [7:0] hold;
   logic own_req, tmo, rel, arb;
   assign ptr     = mode ? last_id : '0;
   assign own_req = req[gnt_id];
   assign tmo     = (TIMEOUT != 0) && (hold == 8'(TIMEOUT - 1));
   assign rel     = done | ~own_req | tmo;
   assign arb     = (state == IDLE) && (|req);
   // search from ptr-1 downwards; later iterations have higher priority
   always_comb begin
      win = '0;
      for (int j = N - 1; j >= 0; j--)
         if (req[ptr - IDW'(1) - IDW'(j)]) win = ptr - IDW'(1) - IDW'(j);
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         gnt_id        <= '0;
         gnt_onehot    <= '0;
         last_id       <= '0;
         hold          <= '0;
         timeout_pulse <= 1'b0;
      end else begin
         state         <= state_nxt;
         timeout_pulse <= (state == GRANT) && tmo && !done && own_req;
         if (arb) begin
            gnt_id     <= win;
            last_id    <= win;
            hold       <= '0;
            gnt_onehot <= N'(1) << win;
         end else if (state == GRANT) begin
            hold <= (hold == 8'hFF) ? hold : hold + 8'd1;
            if (rel) gnt_onehot <= '0;
         end
      end
   end
   always_comb begin
      state_nxt = (state == IDLE) ? (arb ? GRANT : IDLE) : (rel ? IDLE : GRANT);
   end
   always_comb begin
      gnt_valid = (state == GRANT);
   end
endmodule

// File: tb/tb_rr_request_arbiter.sv
// tb_rr_request_arbiter: table vectors, directed corner sequences and a randomized run against a behavioural model.
module tb_rr_request_arbiter;
   localparam int TO = 4;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] req = '0;
   logic        mode = 1'b0;
   logic        done = 1'b0;
   logic        gnt_valid;
   logic [3:0]  gnt_id;
   logic [15:0] gnt_onehot;
   logic        timeout_pulse;
   int errors = 0;
   int checks = 0;
   logic       m_busy, m_pulse;
   logic [3:0] m_owner, m_last;
   int         m_age;

   typedef struct {
      logic [15:0] r;
      logic        m;
      logic        d;
      logic        v;
      logic [3:0]  id;
      logic        p;
   } vec_t;
   vec_t tbl[$];

   rr_request_arbiter #(.N(16), .IDW(4), .TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .mode(mode), .done(done),
      .gnt_valid(gnt_valid), .gnt_id(gnt_id), .gnt_onehot(gnt_onehot),
      .timeout_pulse(timeout_pulse)
   );

   always #5 clk = ~clk;

   function automatic logic [3:0] pick(input logic [15:0] r, input logic md, input logic [3:0] last);
      int p = md ? int'(last) : 0;
      for (int k = 1; k <= 16; k++) begin
         int c = (p - k + 16) % 16;
         if (r[c]) return c[3:0];
      end
      return 4'd0;
   endfunction

   task automatic model_reset();
      m_busy = 1'b0; m_pulse = 1'b0; m_owner = '0; m_last = '0; m_age = 0;
   endtask

   // one rising edge of the specified behaviour, using the inputs present at that edge
   task automatic model_edge();
      logic rd, rq, rt;
      m_pulse = 1'b0;
      if (!m_busy) begin
         if (req != 0) begin
            m_owner = pick(req, mode, m_last);
            m_last  = m_owner;
            m_busy  = 1'b1;
            m_age   = 1;
         end
      end else begin
         rd = done;
         rq = !req[m_owner];
         rt = (TO != 0) && (m_age == TO);
         m_pulse = rt && !rd && !rq;
         if (rd || rq || rt) m_busy = 1'b0;
         else m_age++;
      end
   endtask

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic chk_out(input string nm, input logic v, input logic [3:0] id, input logic p);
      chk({nm, ".valid"}, 16'(gnt_valid), 16'(v));
      chk({nm, ".id"}, 16'(gnt_id), 16'(id));
      chk({nm, ".onehot"}, gnt_onehot, v ? (16'd1 << id) : 16'd0);
      chk({nm, ".tpulse"}, 16'(timeout_pulse), 16'(p));
   endtask

   task automatic cyc(input logic [15:0] r, input logic m, input logic d);
      req = r; mode = m; done = d;
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; req = '0; mode = 1'b0; done = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk_out("reset", 1'b0, 4'd0, 1'b0);
      rst_n = 1'b1;
   endtask

   task automatic add(input logic [15:0] r, input logic m, input logic d,
                      input logic v, input logic [3:0] id, input logic p);
      vec_t e;
      e.r = r; e.m = m; e.d = d; e.v = v; e.id = id; e.p = p;
      tbl.push_back(e);
   endtask

   initial begin
      add(16'h8001, 1'b0, 1'b0, 1'b1, 4'd15, 1'b0);
      add(16'h8001, 1'b0, 1'b0, 1'b1, 4'd15, 1'b0);
      add(16'h8001, 1'b0, 1'b1, 1'b0, 4'd15, 1'b0);
      add(16'h8001, 1'b0, 1'b0, 1'b1, 4'd15, 1'b0);
      add(16'h8001, 1'b0, 1'b1, 1'b0, 4'd15, 1'b0);
      add(16'h0011, 1'b1, 1'b0, 1'b1, 4'd4,  1'b0);
      add(16'h0011, 1'b1, 1'b1, 1'b0, 4'd4,  1'b0);
      add(16'h0011, 1'b1, 1'b0, 1'b1, 4'd0,  1'b0);
      add(16'h0011, 1'b1, 1'b1, 1'b0, 4'd0,  1'b0);
      add(16'h0011, 1'b1, 1'b0, 1'b1, 4'd4,  1'b0);
      add(16'h0011, 1'b1, 1'b1, 1'b0, 4'd4,  1'b0);
      add(16'h0011, 1'b1, 1'b0, 1'b1, 4'd0,  1'b0);
      add(16'h0000, 1'b1, 1'b0, 1'b0, 4'd0,  1'b0);
      add(16'h0080, 1'b0, 1'b0, 1'b1, 4'd7,  1'b0);
      add(16'h0080, 1'b1, 1'b0, 1'b1, 4'd7,  1'b0);
      add(16'h0080, 1'b0, 1'b0, 1'b1, 4'd7,  1'b0);
      add(16'h0080, 1'b0, 1'b0, 1'b1, 4'd7,  1'b0);
      add(16'h0080, 1'b0, 1'b0, 1'b0, 4'd7,  1'b1);
      add(16'h0080, 1'b0, 1'b0, 1'b1, 4'd7,  1'b0);
      add(16'h0000, 1'b0, 1'b0, 1'b0, 4'd7,  1'b0);
      add(16'h0200, 1'b0, 1'b0, 1'b1, 4'd9,  1'b0);
      add(16'h0208, 1'b0, 1'b0, 1'b1, 4'd9,  1'b0);
      add(16'h0008, 1'b0, 1'b0, 1'b0, 4'd9,  1'b0);
      add(16'h0008, 1'b0, 1'b0, 1'b1, 4'd3,  1'b0);
      add(16'h0000, 1'b0, 1'b0, 1'b0, 4'd3,  1'b0);

      do_reset();
      foreach (tbl[i]) begin
         cyc(tbl[i].r, tbl[i].m, tbl[i].d);
         chk_out($sformatf("vec%0d", i), tbl[i].v, tbl[i].id, tbl[i].p);
      end

      // round-robin sweep over all requesters, one bubble between grants
      do_reset();
      for (int i = 0; i <= 16; i++) begin
         cyc(16'hFFFF, 1'b1, 1'b0);
         chk_out($sformatf("sweep%0d", i), 1'b1, 4'((31 - i) % 16), 1'b0);
         cyc(16'hFFFF, 1'b1, 1'b1);
         chk_out($sformatf("bubble%0d", i), 1'b0, 4'((31 - i) % 16), 1'b0);
      end

      // asynchronous reset in the middle of a grant, then pointer restart
      cyc(16'h1000, 1'b0, 1'b0);
      chk_out("pre_rst", 1'b1, 4'd12, 1'b0);
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      chk_out("async_rst", 1'b0, 4'd0, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      cyc(16'h1004, 1'b1, 1'b0);
      chk_out("post_rst", 1'b1, 4'd12, 1'b0);

      do_reset();
      begin
         logic [15:0] r;
         r = 16'h0000;
         for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0)
               r = ($urandom_range(0, 4) == 0) ? 16'h0000 : 16'($urandom & $urandom);
            cyc(r, 1'($urandom), $urandom_range(0, 7) == 0);
            chk_out("rand", m_busy, m_owner, m_pulse);
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
